// File: rtl/circle_arc_engine.sv
// circle_arc_engine: midpoint circle rasteriser emitting one clipped, octant-masked candidate pixel per cycle.
// Pixel outputs are registered from the next-state values so they line up with the PLOT cycle they belong to.
module circle_arc_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [7:0] octant_mask,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);
    typedef enum logic [2:0] {IDLE, INIT, PLOT, UPDATE, DONE} state_t;
    state_t state, state_n;
    logic [2:0] col;
    logic [7:0] cx, rad, mask;
    logic [6:0] cy;
    logic [2:0] oct, oct_n;
    logic signed [9:0] ox, oy, ox_n, oy_n, ox_u, oy_u, dx, dy, px, py;
    logic signed [10:0] crit, crit_n, crit_u;
    logic vis;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        oy_u = oy + 10'sd1;
        ox_u = (crit <= 11'sd0) ? ox : ox - 10'sd1;
        crit_u = crit + 11'sd1 + ((crit <= 11'sd0) ? (11'(oy_u) <<< 1) : (11'(oy_u - ox_u) <<< 1));
        state_n = state;
        ox_n = ox;
        oy_n = oy;
        crit_n = crit;
        oct_n = oct;
        case (state)
            IDLE: state_n = start ? INIT : IDLE;
            INIT: begin
                state_n = PLOT;
                ox_n = $signed({2'b00, rad});
                oy_n = 10'sd0;
                crit_n = 11'sd1 - $signed({3'b000, rad});
                oct_n = 3'd0;
            end
            PLOT: begin
                oct_n = oct + 3'd1;
                state_n = (oct == 3'd7) ? UPDATE : PLOT;
            end
            UPDATE: begin
                ox_n = ox_u;
                oy_n = oy_u;
                crit_n = crit_u;
                oct_n = 3'd0;
                state_n = (oy_u <= ox_u) ? PLOT : DONE;
            end
            DONE: state_n = start ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
        // odd octants swap the offsets; octants 2..5 mirror x, 4..7 mirror y
        dx = oct_n[0] ? oy_n : ox_n;
        dy = oct_n[0] ? ox_n : oy_n;
        px = (oct_n[2] ^ oct_n[1]) ? $signed({2'b00, cx}) - dx : $signed({2'b00, cx}) + dx;
        py = oct_n[2] ? $signed({3'b000, cy}) - dy : $signed({3'b000, cy}) + dy;
        vis = mask[oct_n] && px >= 10'sd0 && px < 10'(SCREEN_W) && py >= 10'sd0 && py < 10'(SCREEN_H);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            col <= '0;
            cx <= '0;
            cy <= '0;
            rad <= '0;
            mask <= '0;
            ox <= '0;
            oy <= '0;
            crit <= '0;
            oct <= '0;
            vga_x <= '0;
            vga_y <= '0;
            vga_colour <= '0;
            vga_plot <= 1'b0;
            done <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                col <= colour;
                cx <= centre_x;
                cy <= centre_y;
                rad <= radius;
                mask <= octant_mask;
            end
            ox <= ox_n;
            oy <= oy_n;
            crit <= crit_n;
            oct <= oct_n;
            vga_x <= px[7:0];
            vga_y <= py[6:0];
            vga_colour <= col;
            vga_plot <= (state_n == PLOT) && vis;
            done <= (state_n == DONE);
        end
endmodule
